// File: rtl/tone_decoder_if.sv
// Audio-in / decoded-note bundle between the tone decoder and note-recognition logic.
interface tone_decoder_if;
  logic        audio_in;
  logic [4:0]  note;
  logic        note_valid;
  logic        note_strobe;
  logic [13:0] period;

  modport master (input audio_in, output note, note_valid, note_strobe, period);
  modport slave  (output audio_in, input note, note_valid, note_strobe, period);
endinterface

// File: rtl/tone_decoder.sv
// Measures the half-period of a square-wave audio line in ticks and decodes it
// back into the song player's note code, with confirmation and silence timeout.
module tone_decoder #(
  parameter int DIV     = 10,
  parameter int TOL     = 64,
  parameter int CONFIRM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tone_decoder_if.master  bus
);
  localparam int          TW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [13:0] HP_MAX = 14'h3fff;

  typedef enum logic [1:0] {SILENT, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic        edge_det, tick, meas, timeout, accept;
  logic [TW-1:0] tick_cnt;
  logic [13:0] hp_cnt, period;
  logic [1:0]  vld_pipe;
  logic [4:0]  cand, last_cand, note;
  logic [3:0]  conf;
  logic        note_valid, note_strobe;

  function automatic logic [13:0] tbl_val(input int i);
    case (i)
      0:  return 14'd11468;  1:  return 14'd10216;  2:  return 14'd9103;
      3:  return 14'd8593;   4:  return 14'd7654;   5:  return 14'd6819;
      6:  return 14'd6074;   7:  return 14'd5737;   8:  return 14'd5112;
      9:  return 14'd4553;   10: return 14'd4297;   11: return 14'd3828;
      12: return 14'd3410;   13: return 14'd3038;   14: return 14'd2868;
      15: return 14'd2555;   16: return 14'd2276;   17: return 14'd2148;
      18: return 14'd1914;   19: return 14'd1706;   20: return 14'd1520;
      default: return 14'd0;
    endcase
  endfunction

  // Table rows 0-6 map to codes 1-7, 7-13 to 11-17, 14-20 to 21-27.
  function automatic logic [4:0] tbl_code(input int i);
    if (i < 7)       return 5'(i + 1);
    else if (i < 14) return 5'(i + 4);
    else             return 5'(i + 7);
  endfunction

  function automatic logic in_tol(input logic [13:0] p, input logic [13:0] v);
    logic [14:0] pe, ve;
    pe = {1'b0, p};
    ve = {1'b0, v};
    return (pe + 15'(TOL) >= ve) && (pe <= ve + 15'(TOL));
  endfunction

  assign edge_det = s2 ^ s3;
  assign tick     = (tick_cnt == TW'(DIV - 1));
  assign meas     = edge_det && (state != SILENT);
  assign timeout  = (hp_cnt == HP_MAX) && !edge_det;
  assign accept   = vld_pipe[1] && (conf == 4'(CONFIRM)) && (last_cand != 5'd0) &&
                    ((note != last_cand) || !note_valid);

  always_comb begin
    cand = '0;
    for (int i = 0; i < 21; i++)
      if (in_tol(period, tbl_val(i))) cand = tbl_code(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      tick_cnt <= '0;
    end else begin
      s1 <= bus.audio_in; s2 <= s1; s3 <= s2;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  // The first edge after silence only restarts the counter; edge beats tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt   <= '0;
      period   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], meas};
      if (edge_det) begin
        hp_cnt <= '0;
        if (meas) period <= hp_cnt;
      end else if (tick && hp_cnt != HP_MAX) begin
        hp_cnt <= hp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf      <= '0;
      last_cand <= '0;
    end else if (timeout) begin
      conf      <= '0;
      last_cand <= '0;
    end else if (vld_pipe[0]) begin
      last_cand <= cand;
      if (cand == 5'd0)            conf <= '0;
      else if (cand == last_cand)  conf <= (conf >= 4'(CONFIRM)) ? 4'(CONFIRM) : conf + 1'b1;
      else                         conf <= 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SILENT;
      note        <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      if (timeout) begin
        state      <= SILENT;
        note       <= '0;
        note_valid <= 1'b0;
      end else begin
        case (state)
          SILENT: if (edge_det) state <= MEASURE;
          MEASURE, LOCKED:
            if (accept) begin
              state       <= LOCKED;
              note        <= last_cand;
              note_valid  <= 1'b1;
              note_strobe <= 1'b1;
            end
          default: state <= SILENT;
        endcase
      end
    end
  end

  assign bus.note        = note;
  assign bus.note_valid  = note_valid;
  assign bus.note_strobe = note_strobe;
  assign bus.period      = period;
endmodule
